// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter.
// Entry layout is reused by the hold registers and the output stage.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 7
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef NUM_OF_ALUS
`define NUM_OF_ALUS 2
`endif
`ifndef NUM_OF_MEM
`define NUM_OF_MEM 1
`endif

package cdb_pkg;

    localparam int TAG_W = `ROB_SIZE_WIDTH;
    localparam int DST_W = `PHYSICAL_REG_NUM_WIDTH;
    localparam int VAL_W = `REG_VAL_WIDTH;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DST_W-1:0] dst;
        logic [VAL_W-1:0] val;
    } cdb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping at N-1. Also usable for reservation-station issue selection.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;

    // scan N positions starting at ptr, take the first requester seen
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU one-entry hold registers feeding a
// round-robin selected, registered CDB broadcast with back-pressure.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = `NUM_OF_ALUS + `NUM_OF_MEM,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CW      = $clog2(NUM_REQ + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      fu_valid,
    output logic [NUM_REQ-1:0]      fu_ready,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] fu_tag,
    input  logic [NUM_REQ-1:0][DST_W-1:0] fu_dst,
    input  logic [NUM_REQ-1:0][VAL_W-1:0] fu_val,
    input  logic                    cdb_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DST_W-1:0]        cdb_dst,
    output logic [VAL_W-1:0]        cdb_val,
    output logic [IW-1:0]           cdb_grant_id,
    output logic [CW-1:0]           pending_cnt
);

    cdb_entry_t         hold [NUM_REQ];
    cdb_entry_t         cdb_q;
    logic [NUM_REQ-1:0] hold_valid;
    logic [NUM_REQ-1:0] hold_next;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] take;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      ptr_next;
    logic [CW-1:0]      cnt_next;
    logic               live;
    logic               adv;

    // flush and reset both block capture and grant in the same cycle
    assign live = reset & ~flush;
    assign adv  = ~cdb_valid | cdb_ready;
    assign req  = (live & adv) ? hold_valid : '0;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // a granted hold can accept a new result while it drains
    assign fu_ready = live ? (~hold_valid | grant) : '0;
    assign take     = fu_valid & fu_ready;

    assign cdb_tag = cdb_q.tag;
    assign cdb_dst = cdb_q.dst;
    assign cdb_val = cdb_q.val;

    assign ptr_next = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

    // next hold occupancy and its popcount for the status counter
    always_comb begin
        hold_next = (hold_valid & ~grant) | take;
        cnt_next  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_next = cnt_next + CW'(hold_next[i]);
        end
    end

    // hold payload capture; occupancy bit qualifies the contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) begin
                hold[i] <= '{tag: fu_tag[i], dst: fu_dst[i], val: fu_val[i]};
            end
        end
    end

    // control state and registered CDB output stage
    always_ff @(posedge clk) begin
        if (!live) begin
            hold_valid   <= '0;
            cdb_valid    <= 1'b0;
            cdb_q        <= '0;
            cdb_grant_id <= '0;
            rr_ptr       <= '0;
            pending_cnt  <= '0;
        end else begin
            hold_valid  <= hold_next;
            pending_cnt <= cnt_next;
            if (adv) begin
                cdb_valid <= |grant;
            end
            if (|grant) begin
                cdb_q        <= hold[gidx];
                cdb_grant_id <= gidx;
                rr_ptr       <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with three requesters.
// Each scenario task drives vectors and compares against hand values.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 7
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module tb_cdb_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic cdb_ready = 1'b1;
    logic [N-1:0] fu_valid = '0;
    logic [N-1:0] fu_ready;
    logic [N-1:0][`ROB_SIZE_WIDTH-1:0] fu_tag = '0;
    logic [N-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0] fu_dst = '0;
    logic [N-1:0][`REG_VAL_WIDTH-1:0] fu_val = '0;
    logic cdb_valid;
    logic [`ROB_SIZE_WIDTH-1:0] cdb_tag;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_dst;
    logic [`REG_VAL_WIDTH-1:0] cdb_val;
    logic [1:0] cdb_grant_id;
    logic [1:0] pending_cnt;

    int cmp = 0;
    int err = 0;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_tag       (fu_tag),
        .fu_dst       (fu_dst),
        .fu_val       (fu_val),
        .cdb_ready    (cdb_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_dst      (cdb_dst),
        .cdb_val      (cdb_val),
        .cdb_grant_id (cdb_grant_id),
        .pending_cnt  (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input int t);
        fu_valid[i] = 1'b1;
        fu_tag[i]   = t[6:0];
        fu_dst[i]   = t[5:0];
        fu_val[i]   = 32'(t * 3);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL rst_valid got %b want 0", cdb_valid);
        end
        cmp++;
        if ({cdb_tag, cdb_dst, cdb_val} !== '0) begin
            err++;
            $display("FAIL rst_payload got %0d/%0d/%0d want 0", cdb_tag, cdb_dst, cdb_val);
        end
        cmp++;
        if (cdb_grant_id !== 2'd0 || pending_cnt !== 2'd0) begin
            err++;
            $display("FAIL rst_id_cnt got %0d/%0d want 0/0", cdb_grant_id, pending_cnt);
        end
        cmp++;
        if (fu_ready !== 3'b000) begin
            err++;
            $display("FAIL rst_ready_low got %b want 000", fu_ready);
        end
        reset = 1'b1;
        #1;
        cmp++;
        if (fu_ready !== 3'b111) begin
            err++;
            $display("FAIL rst_ready_after got %b want 111", fu_ready);
        end
    endtask

    task automatic test_round_robin;
        int id1 [3] = '{0, 1, 2};
        int id2 [3] = '{1, 2, 0};
        cdb_ready = 1'b1;
        put(0, 10); put(1, 11); put(2, 12);
        tick();
        fu_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp++;
            if (cdb_valid !== 1'b1 || cdb_grant_id !== 2'(id1[k])
                || cdb_tag !== 7'(10 + id1[k])) begin
                err++;
                $display("FAIL rr0_%0d got v=%b id=%0d tag=%0d want 1/%0d/%0d",
                         k, cdb_valid, cdb_grant_id, cdb_tag, id1[k], 10 + id1[k]);
            end
        end
        tick();
        put(0, 20);
        tick();
        fu_valid = '0;
        tick();
        tick();
        put(0, 30); put(1, 31); put(2, 32);
        tick();
        fu_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp++;
            if (cdb_valid !== 1'b1 || cdb_grant_id !== 2'(id2[k])
                || cdb_tag !== 7'(30 + id2[k])) begin
                err++;
                $display("FAIL rr1_%0d got v=%b id=%0d tag=%0d want 1/%0d/%0d",
                         k, cdb_valid, cdb_grant_id, cdb_tag, id2[k], 30 + id2[k]);
            end
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL rr_idle got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single;
        fu_valid = '0;
        fu_valid[0] = 1'b1;
        fu_tag[0] = 7'd5;
        fu_dst[0] = 6'd12;
        fu_val[0] = 32'hDEAD;
        tick();
        fu_valid = '0;
        cmp++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 2'd1) begin
            err++;
            $display("FAIL single_t1 got v=%b cnt=%0d want 0/1", cdb_valid, pending_cnt);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 7'd5 || cdb_dst !== 6'd12
            || cdb_val !== 32'hDEAD || cdb_grant_id !== 2'd0) begin
            err++;
            $display("FAIL single_t2 got v=%b %0d/%0d/%h id=%0d want 1 5/12/dead id=0",
                     cdb_valid, cdb_tag, cdb_dst, cdb_val, cdb_grant_id);
        end
        cmp++;
        if (pending_cnt !== 2'd0) begin
            err++;
            $display("FAIL single_cnt got %0d want 0", pending_cnt);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL single_t3 got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_back_pressure;
        int id [3] = '{2, 0, 1};
        int tg [3] = '{42, 40, 43};
        cdb_ready = 1'b0;
        put(0, 40); put(1, 41); put(2, 42);
        tick();
        fu_valid = '0;
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 7'd41 || cdb_grant_id !== 2'd1
            || pending_cnt !== 2'd2) begin
            err++;
            $display("FAIL bp_first got v=%b tag=%0d id=%0d cnt=%0d want 1/41/1/2",
                     cdb_valid, cdb_tag, cdb_grant_id, pending_cnt);
        end
        cmp++;
        if (fu_ready !== 3'b010) begin
            err++;
            $display("FAIL bp_ready_hole got %b want 010", fu_ready);
        end
        put(1, 43);
        tick();
        put(0, 50); put(1, 51); put(2, 52);
        #1;
        cmp++;
        if (fu_ready !== 3'b000) begin
            err++;
            $display("FAIL bp_ready_full got %b want 000", fu_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            cmp++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 7'd41 || cdb_grant_id !== 2'd1
                || fu_ready !== 3'b000 || pending_cnt !== 2'd3) begin
                err++;
                $display("FAIL bp_stall_%0d got v=%b tag=%0d id=%0d rdy=%b cnt=%0d",
                         k, cdb_valid, cdb_tag, cdb_grant_id, fu_ready, pending_cnt);
            end
        end
        fu_valid = '0;
        cdb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 7'(tg[k])
                || cdb_grant_id !== 2'(id[k]) || pending_cnt !== 2'(2 - k)) begin
                err++;
                $display("FAIL bp_drain_%0d got v=%b tag=%0d id=%0d cnt=%0d want 1/%0d/%0d/%0d",
                         k, cdb_valid, cdb_tag, cdb_grant_id, pending_cnt, tg[k], id[k], 2 - k);
            end
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL bp_idle got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_stream;
        cdb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            put(1, k);
            #1;
            cmp++;
            if (fu_ready[1] !== 1'b1) begin
                err++;
                $display("FAIL stream_ready_%0d got %b want 1", k, fu_ready[1]);
            end
            tick();
            if (k > 0) begin
                cmp++;
                if (cdb_valid !== 1'b1 || cdb_tag !== 7'(k - 1)) begin
                    err++;
                    $display("FAIL stream_cdb_%0d got v=%b tag=%0d want 1/%0d",
                             k, cdb_valid, cdb_tag, k - 1);
                end
            end
        end
        fu_valid = '0;
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 7'd7) begin
            err++;
            $display("FAIL stream_last got v=%b tag=%0d want 1/7", cdb_valid, cdb_tag);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL stream_idle got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_flush;
        cdb_ready = 1'b0;
        put(0, 60); put(1, 61); put(2, 62);
        tick();
        fu_valid = '0;
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 7'd62 || pending_cnt !== 2'd2) begin
            err++;
            $display("FAIL fl_pre got v=%b tag=%0d cnt=%0d want 1/62/2",
                     cdb_valid, cdb_tag, pending_cnt);
        end
        flush = 1'b1;
        put(2, 70);
        #1;
        cmp++;
        if (fu_ready !== 3'b000) begin
            err++;
            $display("FAIL fl_ready got %b want 000", fu_ready);
        end
        tick();
        flush = 1'b0;
        fu_valid = '0;
        cmp++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 2'd0) begin
            err++;
            $display("FAIL fl_post got v=%b cnt=%0d want 0/0", cdb_valid, pending_cnt);
        end
        cdb_ready = 1'b1;
        tick();
        tick();
        cmp++;
        if (cdb_valid !== 1'b0 || pending_cnt !== 2'd0) begin
            err++;
            $display("FAIL fl_nocap got v=%b cnt=%0d want 0/0", cdb_valid, pending_cnt);
        end
        put(0, 80); put(1, 81); put(2, 82);
        tick();
        fu_valid = '0;
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_grant_id !== 2'd0 || cdb_tag !== 7'd80) begin
            err++;
            $display("FAIL fl_ptr got v=%b id=%0d tag=%0d want 1/0/80",
                     cdb_valid, cdb_grant_id, cdb_tag);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        cdb_ready = 1'b1;
        put(0, 90); put(1, 91); put(2, 92);
        tick();
        tick();
        tick();
        cmp++;
        if (cdb_valid !== 1'b1) begin
            err++;
            $display("FAIL rm_busy got %b want 1", cdb_valid);
        end
        reset = 1'b0;
        #1;
        cmp++;
        if (fu_ready !== 3'b000) begin
            err++;
            $display("FAIL rm_ready_low got %b want 000", fu_ready);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0 || {cdb_tag, cdb_dst, cdb_val} !== '0
            || cdb_grant_id !== 2'd0 || pending_cnt !== 2'd0) begin
            err++;
            $display("FAIL rm_state got v=%b %0d/%0d/%0d id=%0d cnt=%0d want all 0",
                     cdb_valid, cdb_tag, cdb_dst, cdb_val, cdb_grant_id, pending_cnt);
        end
        reset = 1'b1;
        fu_valid = '0;
        put(1, 93); put(2, 94);
        #1;
        cmp++;
        if (fu_ready !== 3'b111) begin
            err++;
            $display("FAIL rm_ready_after got %b want 111", fu_ready);
        end
        tick();
        fu_valid = '0;
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_grant_id !== 2'd1 || cdb_tag !== 7'd93) begin
            err++;
            $display("FAIL rm_first got v=%b id=%0d tag=%0d want 1/1/93",
                     cdb_valid, cdb_grant_id, cdb_tag);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b1 || cdb_grant_id !== 2'd2 || cdb_tag !== 7'd94) begin
            err++;
            $display("FAIL rm_second got v=%b id=%0d tag=%0d want 1/2/94",
                     cdb_valid, cdb_grant_id, cdb_tag);
        end
        tick();
        cmp++;
        if (cdb_valid !== 1'b0) begin
            err++;
            $display("FAIL rm_idle got %b want 0", cdb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_back_pressure();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the functional-unit results onto the single common data bus (CDB) that feeds the reservation stations, the register status table and the ROB. Each ALU and MEM unit delivers its completed result through a valid/ready port into a one-entry per-requester hold register. A round-robin arbiter then drives one held result per cycle into a registered CDB output stage. The output stage honours the back-pressure that the reservation-station unit asserts on the CDB ready line.

## Interface
- NUM_REQ, default `NUM_OF_ALUS + `NUM_OF_MEM: number of FU requesters; ALUs occupy the low indices, MEM units the high indices.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered results (mispredict/exception).
- fu_valid  in  NUM_REQ  result present on requester i.
- fu_ready  out  NUM_REQ  arbiter accepts the result on requester i this cycle.
- fu_tag  in  NUM_REQ×`ROB_SIZE_WIDTH  ROB tag per requester.
- fu_dst  in  NUM_REQ×`PHYSICAL_REG_NUM_WIDTH  destination physical register per requester.
- fu_val  in  NUM_REQ×`REG_VAL_WIDTH  result value per requester.
- cdb_ready  in  1  the CDB consumer accepts the current broadcast.
- cdb_valid  out  1  broadcast valid.
- cdb_tag / cdb_dst / cdb_val  out  `ROB_SIZE_WIDTH / `PHYSICAL_REG_NUM_WIDTH / `REG_VAL_WIDTH  broadcast payload.
- cdb_grant_id  out  $clog2(NUM_REQ)  index of the requester that was granted the current broadcast.
- pending_cnt  out  $clog2(NUM_REQ+1)  number of occupied hold registers (status/debug).

## Operation
- **Hold stage.** hold_valid[i] plus a payload register per requester.
  - Capture when fu_valid[i] & fu_ready[i].
  - fu_ready[i] = ~hold_valid[i] | grant[i]. This permits a same-cycle drain and refill. The combinational path from cdb_ready to fu_ready is intentional.
- **Output advance.** adv = ~cdb_valid | cdb_ready.
- **Arbitration.**
  - When adv is high, req = hold_valid. grant is one-hot: the first set bit of req, scanning from rr_ptr upward with wrap-around at NUM_REQ-1 → 0.
  - When adv is low, grant is 0.
- **On a grant to requester i:**
  - The output registers load the payload from hold register i.
  - cdb_valid = 1 and cdb_grant_id = i.
  - hold_valid[i] clears unless the port refills in the same cycle.
  - rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- **No grant while adv is high.** cdb_valid = 0 and the payload holds its previous value (don't-care).
- **Back-pressure.** While cdb_valid & ~cdb_ready, the output payload, cdb_grant_id and rr_ptr are frozen. Holds fill and stay put.
- **Fairness.** A pending requester is granted within NUM_REQ grants.
- **pending_cnt.** Popcount of hold_valid, registered, so it reflects the state after the edge.
- **Flush.**
  - On a flush edge: all hold_valid = 0, cdb_valid = 0, rr_ptr = 0.
  - fu_ready is forced to 0 during a flush cycle, so nothing is captured and nothing is granted.
  - Flush takes priority over every capture and grant in the same cycle.
- **Reset.** reset == 0 at an edge produces the same state as flush.
- **Reset values.** cdb_valid = 0, cdb_tag/cdb_dst/cdb_val = 0, cdb_grant_id = 0, pending_cnt = 0, rr_ptr = 0.
  - fu_ready is combinational. It is all-ones the cycle after reset and 0 while reset is low.

## Timing
- **Latency.** fu handshake at edge t → hold valid after t → earliest cdb_valid after edge t+1. Minimum FU-to-CDB latency is 2 cycles.
- **Throughput.** One broadcast per cycle while cdb_ready = 1 and any hold is occupied.
- **Per-requester sustained rate.** 1/cycle when it is the only requester; otherwise 1 per k cycles with k active requesters.
- **Simultaneous events.**
  - The granted hold drains and refills in the same cycle.
  - A non-granted full hold keeps fu_ready = 0.
- **Back-pressure asserted mid-stream.** No result is lost or duplicated.
  - Each accepted fu handshake produces exactly one cdb_valid & cdb_ready transfer, unless flushed first.
- **Reset or flush while a broadcast is stalled.** The broadcast is discarded and the next cycle shows cdb_valid = 0.

## Structure
- **Package cdb_pkg.** typedef cdb_entry_t {tag, dst, val}, built from the existing `ROB_SIZE_WIDTH / `PHYSICAL_REG_NUM_WIDTH / `REG_VAL_WIDTH macros. Hold registers and the output stage use this type.
- **Sub-module rr_arbiter #(N).** Combinational, with inputs req[N] and ptr, and outputs a one-hot grant plus the grant index. It is reusable for RS issue selection. rr_ptr and the update rule live in cdb_arbiter.

## Test plan
- **Single requester.** NUM_REQ = 3; fu_valid[0] = 1 for 1 cycle with tag = 5, dst = 12, val = 0xDEAD.
  - Required: cdb_valid = 1 exactly 2 cycles later with the same payload and grant_id = 0.
  - pending_cnt shows 1 → 0.
- **All requesters valid at once, cdb_ready = 1, rr_ptr = 0.** Required grant order is 0, 1, 2. After refill with rr_ptr = 1, the order is 1, 2, 0.
- **Back-pressure.** cdb_ready = 0 for 4 cycles with all holds full.
  - cdb payload is stable, and fu_ready = 000 with no new captures.
  - After release, 3 consecutive broadcasts are delivered with no loss.
- **Same-cycle drain and refill.** Requester 1 streams continuously alone.
  - Required: fu_ready[1] = 1 every cycle, and cdb_valid stays high continuously with incrementing tags 0..7.
- **Flush.** Flush with 2 holds occupied and cdb_valid = 1 stalled.
  - Next cycle: cdb_valid = 0, pending_cnt = 0, rr_ptr = 0.
  - A fu_valid presented during the flush cycle is not captured.
- **Reset mid-operation.** reset low for 1 cycle while streaming.
  - All outputs take their reset values.
  - Traffic resumes after reset with a first grant to the lowest-index pending requester.
